// File: rtl/input_conditioner.sv
// Board-pin front end: 2-FF synchronisers and debouncers for the five buttons
// and the DIP switch, press pulses and auto-repeat for the direction buttons.

module ic_debounce #(
    parameter int DEBOUNCE_CYCLES = 330000,
    parameter bit RST_VAL         = 1'b0
) (
    input  logic lcd_clk_33m,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic accept
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    // accept is high in the cycle whose closing edge flips level
    assign accept = (s2 != level) && (cnt == CNT_MAX);

    always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= RST_VAL;
            s2    <= RST_VAL;
            level <= RST_VAL;
            cnt   <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module ic_repeat #(
    parameter int REPEAT_DELAY = 16500000,
    parameter int REPEAT_RATE  = 3300000
) (
    input  logic lcd_clk_33m,
    input  logic rst_n,
    input  logic rise,
    input  logic fall,
    output logic pulse
);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DLY_MAX  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_MAX = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DELAY, RATE} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] cnt, cnt_nxt;
    logic          pulse_nxt;

    always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pulse <= pulse_nxt;
        end
    end

    // A release overrides any repeat that would fall due on the same edge
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        pulse_nxt = 1'b0;
        if (fall) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (rise) state_nxt = DELAY;
                end
                DELAY: begin
                    if (cnt == DLY_MAX) begin
                        state_nxt = RATE;
                        cnt_nxt   = '0;
                        pulse_nxt = 1'b1;
                    end
                end
                RATE: begin
                    if (cnt == RATE_MAX) begin
                        cnt_nxt   = '0;
                        pulse_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end
endmodule

module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 330000,
    parameter int REPEAT_DELAY    = 16500000,
    parameter int REPEAT_RATE     = 3300000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic       lcd_clk_33m,
    input  logic       rst_n,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    input  logic       btn_left_raw,
    input  logic       btn_right_raw,
    input  logic       btn_center_raw,
    input  logic [7:0] dip_sw_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_pulse,
    output logic [7:0] dip_sw,
    output logic       dip_changed
);
    localparam int NUM_CH = 13;

    logic [NUM_CH-1:0] raw, level, accept;
    logic [4:0]        rise, press_q, rpt;
    logic [3:0]        fall;
    logic              dip_upd;

    // Channels 0..4 are buttons (idle 0), 5..12 are DIP bits (idle 1 = off)
    assign raw = {dip_sw_raw, btn_center_raw, btn_right_raw, btn_left_raw,
                  btn_down_raw, btn_up_raw};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ic_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_VAL         ((i >= 5) ? 1'b1 : 1'b0)
        ) u_deb (
            .lcd_clk_33m (lcd_clk_33m),
            .rst_n       (rst_n),
            .raw         (raw[i]),
            .level       (level[i]),
            .accept      (accept[i])
        );
    end

    assign rise = accept[4:0] & ~level[4:0];
    assign fall = accept[3:0] & level[3:0];

    for (genvar i = 0; i < 4; i++) begin : g_rpt
        if (REPEAT_EN) begin : g_on
            ic_repeat #(
                .REPEAT_DELAY (REPEAT_DELAY),
                .REPEAT_RATE  (REPEAT_RATE)
            ) u_rpt (
                .lcd_clk_33m (lcd_clk_33m),
                .rst_n       (rst_n),
                .rise        (rise[i]),
                .fall        (fall[i]),
                .pulse       (rpt[i])
            );
        end else begin : g_off
            assign rpt[i] = 1'b0;
        end
    end
    assign rpt[4] = 1'b0;

    always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            press_q     <= '0;
            dip_upd     <= 1'b0;
            dip_changed <= 1'b0;
        end else begin
            press_q     <= rise;
            dip_upd     <= |accept[12:5];
            dip_changed <= dip_upd;
        end
    end

    assign btn_level = level[4:0];
    assign btn_pulse = press_q | rpt;
    assign dip_sw    = level[12:5];
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short debounce/repeat parameters;
// outputs are logged per cycle and compared against hand-derived schedules.

module tb_input_conditioner;
    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int RAT = 3;
    localparam int LOGN = 1024;

    logic       lcd_clk_33m = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up_raw = 0, btn_down_raw = 0, btn_left_raw = 0;
    logic       btn_right_raw = 0, btn_center_raw = 0;
    logic [7:0] dip_sw_raw = 8'hFF;
    logic [4:0] btn_level, btn_pulse;
    logic [7:0] dip_sw;
    logic       dip_changed;

    input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (DLY),
        .REPEAT_RATE     (RAT),
        .REPEAT_EN       (1'b1)
    ) dut (
        .lcd_clk_33m    (lcd_clk_33m),
        .rst_n          (rst_n),
        .btn_up_raw     (btn_up_raw),
        .btn_down_raw   (btn_down_raw),
        .btn_left_raw   (btn_left_raw),
        .btn_right_raw  (btn_right_raw),
        .btn_center_raw (btn_center_raw),
        .dip_sw_raw     (dip_sw_raw),
        .btn_level      (btn_level),
        .btn_pulse      (btn_pulse),
        .dip_sw         (dip_sw),
        .dip_changed    (dip_changed)
    );

    always #5 lcd_clk_33m = ~lcd_clk_33m;

    int         cyc = 0;
    logic [4:0] plog [LOGN];
    logic [4:0] llog [LOGN];
    logic [7:0] dlog [LOGN];
    logic       clog [LOGN];

    always @(posedge lcd_clk_33m) cyc <= cyc + 1;

    // cyc at a falling edge = number of rising edges so far
    always @(negedge lcd_clk_33m) begin
        if (cyc < LOGN) begin
            plog[cyc] <= btn_pulse;
            llog[cyc] <= btn_level;
            dlog[cyc] <= dip_sw;
            clog[cyc] <= dip_changed;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge lcd_clk_33m);
    endtask

    task automatic chk_pulses(input string tag, input int b, input int from, input int to,
                              input int exp_q[$]);
        for (int c = from; c <= to; c++) begin
            logic e;
            e = 1'b0;
            foreach (exp_q[k]) if (exp_q[k] == c) e = 1'b1;
            chk($sformatf("%s+%0d", tag, c - from), 32'(plog[c][b]), 32'(e));
        end
    endtask

    task automatic chk_level(input string tag, input int b, input int from, input int to,
                             input int lo, input int hi);
        for (int c = from; c <= to; c++)
            chk($sformatf("%s+%0d", tag, c - from), 32'(llog[c][b]),
                32'((c >= lo && c <= hi) ? 1 : 0));
    endtask

    initial begin
        int c0, r;
        int q[$];
        int pat[10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

        wait_cyc(3);
        chk("rst_level", 32'(btn_level), 32'h0);
        chk("rst_pulse", 32'(btn_pulse), 32'h0);
        chk("rst_dip", 32'(dip_sw), 32'hFF);
        chk("rst_dchg", 32'(dip_changed), 32'h0);
        rst_n = 1'b1;
        wait_cyc(3);

        // Clean press on up, held 30 cycles: press at +6, repeats from +16 every 3
        // until level falls at +36 (release at +30)
        c0 = cyc;
        btn_up_raw = 1'b1;
        wait_cyc(30);
        btn_up_raw = 1'b0;
        wait_cyc(12);
        q = {c0 + 6};
        for (int t = c0 + 16; t < c0 + 36; t += RAT) q.push_back(t);
        chk_pulses("up_pulse", 0, c0, c0 + 40, q);
        chk_level("up_level", 0, c0, c0 + 40, c0 + 6, c0 + 35);

        // Bouncing center: last 0->1 at +5, single pulse at +11, never repeats
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            btn_center_raw = pat[i][0];
            wait_cyc(1);
        end
        wait_cyc(25);
        btn_center_raw = 1'b0;
        wait_cyc(12);
        q = {c0 + 11};
        chk_pulses("ctr_pulse", 4, c0, c0 + 45, q);
        chk_level("ctr_level", 4, c0, c0 + 45, c0 + 11, c0 + 40);

        // Three-cycle glitch on left is rejected
        c0 = cyc;
        btn_left_raw = 1'b1;
        wait_cyc(3);
        btn_left_raw = 1'b0;
        wait_cyc(12);
        q = {};
        chk_pulses("glitch_pulse", 2, c0, c0 + 14, q);
        chk_level("glitch_level", 2, c0, c0 + 14, -1, -1);

        // Up and right together
        c0 = cyc;
        btn_up_raw = 1'b1;
        btn_right_raw = 1'b1;
        wait_cyc(8);
        btn_up_raw = 1'b0;
        btn_right_raw = 1'b0;
        wait_cyc(20);
        chk("sim_pre", 32'(plog[c0 + 5]), 32'h0);
        chk("sim_pulse", 32'(plog[c0 + 6]), 32'h09);
        chk("sim_post", 32'(plog[c0 + 7]), 32'h0);

        // DIP: FF -> FB, then bit 3 two cycles later -> F3
        c0 = cyc;
        dip_sw_raw = 8'hFB;
        wait_cyc(2);
        dip_sw_raw = 8'hF3;
        wait_cyc(14);
        chk("dip_c5", 32'(dlog[c0 + 5]), 32'hFF);
        chk("dip_c6", 32'(dlog[c0 + 6]), 32'hFB);
        chk("dip_c7", 32'(dlog[c0 + 7]), 32'hFB);
        chk("dip_c8", 32'(dlog[c0 + 8]), 32'hF3);
        for (int c = c0; c <= c0 + 14; c++)
            chk($sformatf("dchg+%0d", c - c0), 32'(clog[c]),
                32'((c == c0 + 7 || c == c0 + 9) ? 1 : 0));

        // Down held into RATE, then reset mid-repeat
        c0 = cyc;
        btn_down_raw = 1'b1;
        wait_cyc(20);
        chk("dn_rpt1", 32'(plog[c0 + 16][1]), 32'h1);
        chk("dn_rpt2", 32'(plog[c0 + 19][1]), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", 32'(btn_level), 32'h0);
        chk("mid_rst_pulse", 32'(btn_pulse), 32'h0);
        chk("mid_rst_dip", 32'(dip_sw), 32'hFF);
        chk("mid_rst_dchg", 32'(dip_changed), 32'h0);
        wait_cyc(2);
        rst_n = 1'b1;
        r = cyc;
        wait_cyc(24);
        q = {r + 6, r + 16, r + 19, r + 22};
        chk_pulses("rst_dn_pulse", 1, r, r + 22, q);
        chk("rst_dip_c5", 32'(dlog[r + 5]), 32'hFF);
        chk("rst_dip_c6", 32'(dlog[r + 6]), 32'hF3);
        chk("rst_dchg_c7", 32'(clog[r + 7]), 32'h1);
        chk("rst_dchg_c8", 32'(clog[r + 8]), 32'h0);
        btn_down_raw = 1'b0;
        wait_cyc(10);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
